// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
// Shared UART definitions used by the TX arbiter and the uarttx/uartrx wrappers.
package uart_pkg;

    // Byte width of the uarttx/uartrx data path.
    localparam int unsigned UART_DATA_W = 8;

    // TX arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
`timescale 1ns / 1ps
// Combinational round-robin picker.
// The search starts one position above 'last' and wraps around. The request vector is
// rotated through a double-width copy, then the lowest set bit is priority-encoded.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    gnt_onehot,
    output logic [IdxW-1:0] gnt_idx,
    output logic            any
);

    int unsigned    start_i;
    int unsigned    off_i;
    int unsigned    sum_i;
    logic [2*N-1:0] dbl_rot;
    logic [N-1:0]   rot;

    // Rotate so the position after 'last' lands at bit 0, then take the lowest set bit.
    always_comb begin
        start_i = (int'(last) >= int'(N) - 1) ? 0 : int'(last) + 1;
        dbl_rot = {req, req} >> start_i;
        rot     = N'(dbl_rot);
        any     = |req;
        off_i   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off_i = i;
            end
        end
        sum_i = start_i + off_i;
        if (sum_i >= N) begin
            sum_i = sum_i - N;
        end
        gnt_idx    = IdxW'(sum_i);
        gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns / 1ps
// Shares one uarttx transmitter between N_REQ byte producers.
// Requesters are served round-robin and only one byte is in flight at a time. If the
// transmitter never raises tx_busy after a start pulse, the slot is abandoned and the byte
// is dropped.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = UART_DATA_W,
    parameter int unsigned BUSY_TIMEOUT = 16,
    localparam int unsigned IdW         = $clog2(N_REQ),
    localparam int unsigned CntW        = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1
) (
    input  logic                      clk50,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IdW-1:0]            grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  ready_q, ready_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IdW-1:0]    grant_q, grant_d;
    logic              active_q, active_d;
    logic              terr_q, terr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IdW-1:0]    pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] pick_byte;

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .req        (req_valid),
        .last       (grant_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Select the winner's byte from the flattened request bus.
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_byte = pick_byte | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic. ready/start/timeout are single-cycle pulses that default to 0.
    always_comb begin
        state_d  = state_q;
        ready_d  = '0;
        start_d  = 1'b0;
        data_d   = data_q;
        grant_d  = grant_q;
        active_d = active_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                // A busy transmitter in idle means someone else is using it.
                if (pick_any && !tx_busy) begin
                    data_d   = pick_byte;
                    ready_d  = pick_onehot;
                    start_d  = 1'b1;
                    grant_d  = pick_idx;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ARB_WAIT_BUSY;
                end
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
                    // The byte was already acked to its producer; it is lost here.
                    terr_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = ARB_IDLE;
            end
        endcase
    end

    // State and output registers. After reset the search begins at requester 0.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            ready_q  <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            grant_q  <= IdW'(N_REQ - 1);
            active_q <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns / 1ps
// Bench for uart_tx_arbiter. A behavioural transmitter drives tx_busy; a transaction-level
// reference model predicts every output each cycle.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    // Reference model phases: TX free, waiting for busy to rise, frame being sent.
    localparam int PH_FREE    = 0;
    localparam int PH_AWAIT   = 1;
    localparam int PH_SENDING = 2;

    logic           clk50 = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           timeout_err;

    always #10 clk50 = ~clk50;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .DATA_W       (W),
        .BUSY_TIMEOUT (T)
    ) dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int           m_phase;
    int           m_last;
    int           m_waited;
    logic [N-1:0] m_ready;
    logic         m_start;
    logic [W-1:0] m_data;
    logic         m_active;
    logic         m_terr;

    // Behavioural transmitter and producer controls.
    int bd_wait;
    int bd_len;
    int dly_mode;
    int len_max;
    int ext_pct;
    bit busy_force;
    bit auto_prod;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = PH_FREE;
        m_last   = N - 1;
        m_waited = 0;
        m_ready  = '0;
        m_start  = 1'b0;
        m_data   = '0;
        m_active = 1'b0;
        m_terr   = 1'b0;
    endtask

    // One clock edge of the reference: rotate-search grant, busy wait with timeout, frame done.
    task automatic model_step();
        int  w;
        int  c;
        bit  found;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_ready = '0;
        m_start = 1'b0;
        m_terr  = 1'b0;
        found   = 1'b0;
        w       = 0;
        if (m_phase == PH_FREE) begin
            if (req_valid != '0 && !tx_busy) begin
                for (int o = 1; o <= N; o++) begin
                    c = (m_last + o) % N;
                    if (!found && req_valid[c]) begin
                        found = 1'b1;
                        w     = c;
                    end
                end
                m_ready[w] = 1'b1;
                m_start    = 1'b1;
                m_data     = req_data[w*W +: W];
                m_last     = w;
                m_active   = 1'b1;
                m_waited   = 0;
                m_phase    = PH_AWAIT;
            end
        end else if (m_phase == PH_AWAIT) begin
            if (tx_busy) begin
                m_phase = PH_SENDING;
            end else begin
                m_waited++;
                if (m_waited == T) begin
                    m_terr   = 1'b1;
                    m_active = 1'b0;
                    m_phase  = PH_FREE;
                end
            end
        end else begin
            if (!tx_busy) begin
                m_active = 1'b0;
                m_phase  = PH_FREE;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("req_ready", req_ready, m_ready);
        check_eq("tx_start", tx_start, m_start);
        check_eq("tx_data", tx_data, m_data);
        check_eq("grant_id", grant_id, m_last);
        check_eq("active", active, m_active);
        check_eq("timeout_err", timeout_err, m_terr);
    endtask

    function automatic int pick_delay();
        int r;
        if (dly_mode == 0) return int'($urandom_range(3, 0));
        if (dly_mode == 1) return -1;
        r = int'($urandom_range(9, 0));
        if (r < 6) return int'($urandom_range(3, 0));
        if (r < 8) return int'($urandom_range(18, 13));
        return -1;
    endfunction

    // Transmitter: busy rises some cycles after tx_start (or never), stays up for a frame.
    task automatic drive_busy();
        if (busy_force) begin
            tx_busy = 1'b1;
            return;
        end
        if (tx_start) bd_wait = pick_delay();
        if (tx_busy) begin
            bd_len--;
            if (bd_len <= 0) tx_busy = 1'b0;
        end else if (bd_wait == 0) begin
            tx_busy = 1'b1;
            bd_len  = int'($urandom_range(len_max, 1));
            bd_wait = -1;
        end else if (bd_wait > 0) begin
            bd_wait--;
        end else if (ext_pct > 0 && int'($urandom_range(99, 0)) < ext_pct) begin
            tx_busy = 1'b1;
            bd_len  = int'($urandom_range(8, 1));
        end
    endtask

    // Random producers: hold data while valid, refill or drop after ready, sometimes withdraw.
    task automatic drive_prod();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                req_valid[i] = 1'($urandom_range(1, 0));
                req_data[i*W +: W] = W'($urandom);
            end else if (!req_valid[i]) begin
                if ($urandom_range(99, 0) < 30) begin
                    req_valid[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom);
                end
            end else if ($urandom_range(99, 0) < 2) begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk50);
        model_step();
        @(negedge clk50);
        compare_all();
        drive_busy();
        if (auto_prod) drive_prod();
    endtask

    task automatic wait_for_ready(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cycle();
            if (req_ready != '0) seen = 1'b1;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (m_phase == PH_FREE && !tx_busy && bd_wait < 0) ok = 1'b1;
            else cycle();
        end
        check_eq("idle_reached", ok, 1);
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset_n = 1'b0;
        tx_busy = 1'b0;
        bd_wait = -1;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        bit seen;
        int cnt;
        reset_n    = 1'b0;
        req_valid  = '1;
        tx_busy    = 1'b0;
        busy_force = 1'b0;
        auto_prod  = 1'b0;
        dly_mode   = 0;
        len_max    = 80;
        ext_pct    = 0;
        bd_wait    = -1;
        bd_len     = 0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
        model_reset();

        // Reset held with every requester valid; release gives requester 0 first.
        repeat (3) cycle();
        reset_n = 1'b1;
        wait_for_ready(5, seen);
        check_eq("rst_first_seen", seen, 1);
        check_eq("rst_first_gnt", grant_id, 0);
        req_valid = '0;
        wait_idle();

        // Single requester.
        req_valid = 4'b0100;
        req_data[2*W +: W] = 8'hA5;
        wait_for_ready(5, seen);
        check_eq("single_seen", seen, 1);
        check_eq("single_ready", req_ready, 4'b0100);
        check_eq("single_data", tx_data, 8'hA5);
        check_eq("single_start", tx_start, 1);
        req_valid = '0;
        wait_idle();

        // Round-robin with all valids held from a fresh reset.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
        req_valid = '1;
        for (int g = 0; g < 8; g++) begin
            wait_for_ready(300, seen);
            check_eq("rr_seen", seen, 1);
            check_eq("rr_gid", grant_id, g % N);
            check_eq("rr_data", tx_data, 8'h10 + (g % N));
        end
        req_valid = '0;
        wait_idle();

        // External use of the transmitter blocks grants until busy drops.
        busy_force = 1'b1;
        tx_busy    = 1'b1;
        req_valid  = 4'b0001;
        req_data[0 +: W] = 8'h3C;
        repeat (8) begin
            cycle();
            check_eq("busy_block_ready", req_ready, 0);
        end
        busy_force = 1'b0;
        tx_busy    = 1'b0;
        cycle();
        check_eq("busy_release_gnt", req_ready, 4'b0001);
        req_valid = '0;
        wait_idle();

        // Transmitter never answers: timeout pulse 16 cycles after the start pulse.
        dly_mode = 1;
        req_valid = 4'b0001;
        req_data[0 +: W] = 8'h5A;
        wait_for_ready(5, seen);
        check_eq("to_start_seen", seen, 1);
        req_valid = '0;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            cnt++;
            if (timeout_err) seen = 1'b1;
        end
        check_eq("to_seen", seen, 1);
        check_eq("to_latency", cnt, T);
        dly_mode  = 0;
        req_valid = 4'b0001;
        wait_for_ready(10, seen);
        check_eq("post_to_gnt", req_ready, 4'b0001);
        req_valid = '0;
        wait_idle();

        // Reset in the middle of a frame.
        req_valid = 4'b0010;
        wait_for_ready(10, seen);
        check_eq("mid_gnt_seen", seen, 1);
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (m_phase == PH_SENDING) seen = 1'b1;
            else cycle();
        end
        check_eq("mid_sending", seen, 1);
        reset_n = 1'b0;
        tx_busy = 1'b0;
        bd_wait = -1;
        model_reset();
        #1;
        check_eq("mid_rst_active", active, 0);
        compare_all();
        cycle();
        cycle();
        reset_n = 1'b1;
        repeat (20) begin
            cycle();
            check_eq("mid_no_ready", req_ready, 0);
        end

        // Randomised traffic with mixed busy behaviour.
        dly_mode  = 2;
        len_max   = 30;
        ext_pct   = 3;
        auto_prod = 1'b1;
        repeat (4000) cycle();
        auto_prod = 1'b0;
        ext_pct   = 0;
        dly_mode  = 0;
        req_valid = '0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
